// File: rtl/rgb888_to_vga24.sv
// rgb888_to_vga24: packs R/G/B channels into a 24-bit VGA word behind a registered 2-entry skid buffer.
// Build option: define RGB888_BIT_REPLICATE_EN to expand narrow channels by bit replication instead of zero padding.
module rgb888_to_vga24 #(
  parameter int WIDTH_RED   = 8,
  parameter int WIDTH_GREEN = 8,
  parameter int WIDTH_BLUE  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [WIDTH_RED-1:0]   r,
  input  logic [WIDTH_GREEN-1:0] g,
  input  logic [WIDTH_BLUE-1:0]  b,
  input  logic                   s_sof,
  input  logic                   s_eol,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [23:0]            vga_data,
  output logic                   m_sof,
  output logic                   m_eol
);

  function automatic logic [7:0] expand(input logic [7:0] c, input int w);
    logic [7:0] e;
    e = '0;
`ifdef RGB888_BIT_REPLICATE_EN
    for (int i = 0; i < 8; i++) e[7-i] = c[w-1-(i%w)];
`else
    e = c << (8 - w);
`endif
    return e;
  endfunction

  logic [25:0] in_payload, main_q, main_d, skid_q, skid_d;
  logic        main_valid, main_valid_d, skid_full, skid_full_d, ready_q, in_acc;

  assign in_acc     = s_valid && ready_q;
  assign in_payload = {s_sof, s_eol, expand(8'(r), WIDTH_RED), expand(8'(g), WIDTH_GREEN),
                       expand(8'(b), WIDTH_BLUE)};

  // Main register refills from the skid first, then from the input; a stalled main spills the input into the skid.
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid;
    skid_d       = skid_q;
    skid_full_d  = skid_full;
    if (!main_valid || m_ready) begin
      main_valid_d = skid_full || in_acc;
      main_d       = skid_full ? skid_q : in_acc ? in_payload : main_q;
      skid_full_d  = 1'b0;
    end else if (in_acc) begin
      skid_d      = in_payload;
      skid_full_d = 1'b1;
    end
  end

  // State registers; ready is a flop so m_ready never reaches s_ready combinationally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q     <= '0;
      main_valid <= 1'b0;
      skid_q     <= '0;
      skid_full  <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      main_q     <= main_d;
      main_valid <= main_valid_d;
      skid_q     <= skid_d;
      skid_full  <= skid_full_d;
      ready_q    <= !skid_full_d;
    end
  end

  assign s_ready                  = ready_q;
  assign m_valid                  = main_valid;
  assign {m_sof, m_eol, vga_data} = main_q;

endmodule

// File: tb/tb_rgb888_to_vga24.sv
// tb_rgb888_to_vga24: random and directed checks of the packer against a 2-deep FIFO reference model.
module tb_rgb888_to_vga24;
  logic clk = 0, rst_n = 0;
  logic s_valid = 0, m_ready = 1, s_sof = 0, s_eol = 0;
  logic [7:0] r = 0, g = 0, b = 0;
  logic s_ready, m_valid, m_sof, m_eol;
  logic [23:0] vga_data;
  logic s_valid2 = 0, m_ready2 = 1, s_sof2 = 0, s_eol2 = 0;
  logic [4:0] r2 = 0, b2 = 0;
  logic [5:0] g2 = 0;
  logic s_ready2, m_valid2, m_sof2, m_eol2;
  logic [23:0] vga_data2;
  logic [25:0] q[$];
  bit rdy_ok = 0;
  int n_cmp = 0, n_bad = 0, n_acc = 0;

  always #5 clk = ~clk;

  rgb888_to_vga24 dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .r(r), .g(g), .b(b),
    .s_sof(s_sof), .s_eol(s_eol), .m_valid(m_valid), .m_ready(m_ready), .vga_data(vga_data),
    .m_sof(m_sof), .m_eol(m_eol)
  );

  rgb888_to_vga24 #(.WIDTH_RED(5), .WIDTH_GREEN(6), .WIDTH_BLUE(5)) dut565 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid2), .s_ready(s_ready2), .r(r2), .g(g2), .b(b2),
    .s_sof(s_sof2), .s_eol(s_eol2), .m_valid(m_valid2), .m_ready(m_ready2), .vga_data(vga_data2),
    .m_sof(m_sof2), .m_eol(m_eol2)
  );

  function automatic logic [7:0] ex(input logic [7:0] c, input int w);
    logic [63:0] t;
    t = '0;
`ifdef RGB888_BIT_REPLICATE_EN
    for (int k = 0; k < 8; k++) t = (t << w) | 64'(c);
    return 8'(t >> (8 * w - 8));
`else
    t = 64'(c) << (8 - w);
    return 8'(t);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    bit in_acc, out_acc, in2;
    logic [25:0] pl;
    logic [23:0] e2;
    in_acc  = s_valid && rst_n && rdy_ok && (q.size() < 2);
    out_acc = m_ready && (q.size() > 0);
    pl      = {s_sof, s_eol, r, g, b};
    in2     = s_valid2 && rst_n && rdy_ok;
    e2      = {ex(8'(r2), 5), ex(8'(g2), 6), ex(8'(b2), 5)};
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      rdy_ok = 0;
    end else begin
      if (out_acc) void'(q.pop_front());
      if (in_acc) begin
        q.push_back(pl);
        n_acc++;
      end
      rdy_ok = 1;
    end
    #1;
    chk("m_valid", 32'(m_valid), 32'(q.size() > 0));
    chk("s_ready", 32'(s_ready), 32'(rdy_ok && q.size() < 2));
    if (q.size() > 0) chk("beat", 32'({m_sof, m_eol, vga_data}), 32'(q[0]));
    if (!rst_n) chk("rst_out", 32'({m_sof, m_eol, vga_data}), 32'h0);
    chk("m_valid565", 32'(m_valid2), 32'(in2));
    if (in2) chk("data565", 32'(vga_data2), 32'(e2));
  endtask

  initial begin
    int start;
    s_valid = 1;
    repeat (3) cyc();
    rst_n = 1;
    s_valid = 0;
    cyc();
    chk("ready_after_rst", 32'(s_ready), 32'h1);
    s_valid = 1; r = 8'h12; g = 8'h34; b = 8'h56;
    cyc();
    chk("pack", 32'(vga_data), 32'h123456);
    for (int i = 0; i < 16; i++) begin
      s_valid = 1; s_sof = (i == 0); s_eol = (i == 15);
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
      cyc();
      chk("stream_ready", 32'(s_ready), 32'h1);
    end
    s_valid = 0; s_sof = 0; s_eol = 0;
    cyc();
    cyc();
    m_ready = 0;
    s_valid = 1; r = 8'hA1; g = 8'hA2; b = 8'hA3;
    cyc();
    r = 8'hB1; g = 8'hB2; b = 8'hB3;
    cyc();
    chk("stall_full", 32'(s_ready), 32'h0);
    r = 8'hC1; g = 8'hC2; b = 8'hC3;
    cyc();
    cyc();
    chk("stall_hold", 32'(vga_data), 32'hA1A2A3);
    m_ready = 1;
    cyc();
    chk("drain_b", 32'(vga_data), 32'hB1B2B3);
    cyc();
    s_valid = 0;
    cyc();
    chk("drain_c", 32'(vga_data), 32'hC1C2C3);
    cyc();
    s_valid2 = 1; r2 = 5'b10110; g2 = 6'h3F; b2 = 5'h0;
    cyc();
`ifdef RGB888_BIT_REPLICATE_EN
    chk("expand", 32'(vga_data2), 32'hB5FF00);
`else
    chk("expand", 32'(vga_data2), 32'hB0FC00);
`endif
    s_valid2 = 0;
    m_ready = 0;
    s_valid = 1;
    r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
    cyc();
    r = 8'($urandom);
    cyc();
    chk("skid_full", 32'(s_ready), 32'h0);
    rst_n = 0;
    cyc();
    rst_n = 1; s_valid = 0; m_ready = 1;
    repeat (3) cyc();
    start = n_acc;
    for (int i = 0; i < 40000 && n_acc < start + 10000; i++) begin
      s_valid = ($urandom % 4) != 0;
      m_ready = ($urandom % 3) != 0;
      s_sof = 1'($urandom); s_eol = 1'($urandom);
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
      s_valid2 = 1'($urandom);
      r2 = 5'($urandom); g2 = 6'($urandom); b2 = 5'($urandom);
      cyc();
    end
    chk("soak_budget", 32'(n_acc >= start + 10000), 32'h1);
    s_valid = 0; s_valid2 = 0; m_ready = 1;
    repeat (3) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rgb888_to_vga24.md
Name: rgb888_to_vga24

Overview:
- Streaming packer: takes per-channel RGB components of parameterised width and produces the 24-bit VGA pixel word, R in [23:16], G in [15:8], B in [7:0].
- Sits on the write side of the video path and feeds 24-bit VGA sinks, e.g. frame buffer writer or output FIFO.
- Valid/ready handshake on both sides.
- Registered 2-entry skid buffer, so the input is never stalled by combinational backpressure.
- Frame/line sideband flags travel aligned with each pixel.

Parameters:
- WIDTH_RED, 8, red input width; legal 1..8.
- WIDTH_GREEN, 8, green input width; legal 1..8.
- WIDTH_BLUE, 8, blue input width; legal 1..8.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst_n  input  1  synchronous reset, active low.
- s_valid  input  1  input pixel valid.
- s_ready  output  1  block can accept an input pixel.
- r  input  WIDTH_RED  red component.
- g  input  WIDTH_GREEN  green component.
- b  input  WIDTH_BLUE  blue component.
- s_sof  input  1  first pixel of frame.
- s_eol  input  1  last pixel of line.
- m_valid  output  1  output word valid.
- m_ready  input  1  sink accepts output word.
- vga_data  output  24  packed pixel.
- m_sof  output  1  sof aligned with vga_data.
- m_eol  output  1  eol aligned with vga_data.

Behaviour:
Interface (already decided):
- One clock, clk.
- Reset rst_n is synchronous and active low.

Reset:
- While rst_n is sampled low at a clk edge: m_valid=0, s_ready=0, vga_data=0, m_sof=0, m_eol=0, skid entry cleared.
- s_ready rises at the first edge with rst_n high.
- Reset mid-transfer discards both buffered entries. No output beat may appear after reset deasserts until a new input beat is accepted.

Handshake:
- Input beat transfers on an edge where s_valid && s_ready.
- Output beat transfers on an edge where m_valid && m_ready.
- m_valid, vga_data, m_sof and m_eol are stable while m_valid=1 && m_ready=0.
- s_ready is driven directly from a flop: s_ready = !skid_full.
- No combinational path from m_ready to s_ready.

Datapath:
- Each channel is expanded to 8 bits, then the three are concatenated into one 26-bit payload {sof, eol, R8, G8, B8}.
- Width 8 passes through unchanged.
- Expansion rule is set by the Optional Feature.

Skid buffer (main register + skid register):
- Latency: an accepted input appears on vga_data at the next edge when the main register is empty or draining.
- Main register empty, or draining this cycle (m_ready=1): accepted input loads the main register; m_valid=1.
- Main register full and stalled (m_ready=0) with input accepted: payload goes to the skid register; skid_full=1; s_ready=0 next cycle.
- Output transfers and skid is full: skid loads the main register; skid_full=0; s_ready=1 next cycle.
- Output transfers, no skid entry, no input accepted: m_valid=0.
- Accept and drain in the same cycle with skid empty: main register reloads; m_valid stays 1. Throughput is 1 pixel/clk with no bubble.
- Capacity is 2 entries. A third input while stalled is not accepted because s_ready=0.
- Order is strictly FIFO; no beat is ever dropped or duplicated.

Optional Feature:
Macro RGB888_BIT_REPLICATE_EN.
- Defined: each narrow channel is expanded by repeating its bit pattern MSB-first until 8 bits are filled, then truncated to 8. Full scale maps to 0xFF.
  - 5-bit 5'b10110 -> 8'b10110101.
  - 1-bit 1 -> 8'hFF.
  - 3-bit 3'b101 -> 8'b10110110.
- Undefined: channel is left-aligned and zero-padded, 8'b{c, 0...}. This is the exact inverse of MSB truncation.
  - 5'b10110 -> 8'b10110000.
  - 1-bit 1 -> 8'h80.

Test Plan:
1. Reset and packing:
   - Stimulus: rst_n low 3 cycles with s_valid=1; then release; then 8/8/8 beat r=0x12 g=0x34 b=0x56 with m_ready=1.
   - Response: during reset m_valid=0 and s_ready=0; s_ready=1 one edge after release; next edge vga_data=0x123456 with m_valid=1.
2. Streaming:
   - Stimulus: 16 back-to-back beats with m_ready=1; sof on beat 0, eol on beat 15.
   - Response: 16 output beats on consecutive cycles; m_sof on the first, m_eol on the last; s_ready constantly 1.
3. Stall:
   - Stimulus: m_ready=0 while beats A, B, C are offered.
   - Response: A and B accepted; s_ready=0 after B; C held off; outputs held at A; after m_ready=1 the order is A, B, C and s_ready returns to 1 one edge after the skid drains.
4. Expansion, RGB888_BIT_REPLICATE_EN defined:
   - Stimulus: WIDTH 5/6/5, r=5'b10110, g=6'h3F, b=0.
   - Response: vga_data=0xB5FF00.
5. Expansion, RGB888_BIT_REPLICATE_EN undefined:
   - Stimulus: same beat as scenario 4.
   - Response: vga_data=0xB0FC00.
6. Mid-stall reset:
   - Stimulus: skid full, then rst_n low for 1 cycle.
   - Response: m_valid=0 and s_ready=0 at that edge; no stale beat after release; random valid/ready soak of 10k beats matches a scoreboard.
